// File: rtl/vlc_tx_framer.sv
// Manchester-coded VLC frame transmitter: preamble, SFD, length, payload, optional CRC-8 (define TX_CRC8_EN).
// Latency: first DAC sample one cycle after i_start; all outputs registered.
// Backpressure: none accepted; o_ready is a 1-cycle strobe and a missing i_valid aborts the frame with o_err.
module vlc_tx_framer #(
    parameter int         WIDTH            = 10,
    parameter int         SAMPLES_PER_CHIP = 4,
    parameter int         PREAMBLE_BYTES   = 2,
    parameter logic [7:0] SFD              = 8'hA7,
    parameter int         LEVEL_HI         = 1023,
    parameter int         LEVEL_LO         = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [7:0]       i_len,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_tx_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);
    localparam int              SW        = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
    localparam logic [SW-1:0]   SAMP_LAST = SW'(SAMPLES_PER_CHIP - 1);
    localparam logic [7:0]      PRE_LAST  = 8'(PREAMBLE_BYTES - 1);
    localparam logic [WIDTH-1:0] HI       = WIDTH'(LEVEL_HI);
    localparam logic [WIDTH-1:0] LO       = WIDTH'(LEVEL_LO);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_LEN, S_PAYLOAD,
`ifdef TX_CRC8_EN
        S_CRC,
`endif
        S_DONE
    } state_t;

    state_t        state, ns, tail_state;
    logic [7:0]    cur_byte, nb, tail_byte, len, byte_cnt;
    logic [2:0]    bit_idx, bit_n;
    logic          chip, chip_n;
    logic [SW-1:0] samp, samp_n;
    logic          samp_last, byte_end, next_last, more_payload;

    // Chip 0 carries the bit value, chip 1 its complement.
    function automatic logic [WIDTH-1:0] level(input logic b, input logic c);
        return (b ^ c) ? HI : LO;
    endfunction

`ifdef TX_CRC8_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction
`endif

    always_comb begin
        samp_last    = (samp == SAMP_LAST);
        byte_end     = samp_last && chip && (bit_idx == 3'd0);
        samp_n       = samp_last ? '0 : samp + SW'(1);
        chip_n       = samp_last ? ~chip : chip;
        bit_n        = (samp_last && chip) ? bit_idx - 3'd1 : bit_idx;
        next_last    = !byte_end && (samp_n == SAMP_LAST) && chip_n && (bit_n == 3'd0);
        more_payload = ((state == S_LEN) && (len != 8'd0)) ||
                       ((state == S_PAYLOAD) && (byte_cnt != len - 8'd1));
`ifdef TX_CRC8_EN
        tail_state = S_CRC;
        tail_byte  = crc;
`else
        tail_state = S_DONE;
        tail_byte  = cur_byte;
`endif
        ns = state;
        nb = cur_byte;
        case (state)
            S_PREAMBLE: if (byte_cnt == PRE_LAST) begin
                            ns = S_SFD;
                            nb = SFD;
                        end else begin
                            nb = 8'h55;
                        end
            S_SFD:      begin ns = S_LEN; nb = len; end
            S_LEN, S_PAYLOAD:
                        if (more_payload) begin
                            ns = S_PAYLOAD;
                            nb = i_data;
                        end else begin
                            ns = tail_state;
                            nb = tail_byte;
                        end
`ifdef TX_CRC8_EN
            S_CRC:      ns = S_DONE;
`endif
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cur_byte <= '0;
            bit_idx  <= '0;
            chip     <= 1'b0;
            samp     <= '0;
            len      <= '0;
            byte_cnt <= '0;
            o_tx_out <= LO;
            o_busy   <= 1'b0;
            o_ready  <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
`ifdef TX_CRC8_EN
            crc      <= '0;
`endif
        end else begin
            o_ready <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_tx_out <= LO;
                    if (i_start) begin
                        state    <= S_PREAMBLE;
                        len      <= i_len;
                        cur_byte <= 8'h55;
                        bit_idx  <= 3'd7;
                        chip     <= 1'b0;
                        samp     <= '0;
                        byte_cnt <= '0;
                        o_busy   <= 1'b1;
                        o_tx_out <= level(1'b0, 1'b0);
`ifdef TX_CRC8_EN
                        crc      <= '0;
`endif
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (!byte_end) begin
                        samp     <= samp_n;
                        chip     <= chip_n;
                        bit_idx  <= bit_n;
                        o_tx_out <= level(cur_byte[bit_n], chip_n);
                        o_ready  <= next_last && more_payload;
                    end else if (more_payload && !i_valid) begin
                        state    <= S_IDLE;
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_tx_out <= LO;
                    end else begin
                        // Byte boundary: the first sample of the next byte follows with no gap.
                        state    <= ns;
                        cur_byte <= nb;
                        samp     <= '0;
                        chip     <= 1'b0;
                        bit_idx  <= 3'd7;
                        byte_cnt <= (ns == state) ? byte_cnt + 8'd1 : 8'd0;
                        if (ns == S_DONE) begin
                            o_done   <= 1'b1;
                            o_busy   <= 1'b0;
                            o_tx_out <= LO;
                        end else begin
                            o_tx_out <= level(nb[7], 1'b0);
                        end
`ifdef TX_CRC8_EN
                        if (ns == S_LEN || ns == S_PAYLOAD)
                            crc <= crc8(crc, nb);
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vlc_tx_framer.sv
// Directed bench for vlc_tx_framer: reset, 1-byte, empty, underrun and mid-frame start/reset frames.
module tb_vlc_tx_framer;
    localparam int NC = 460;
`ifdef TX_CRC8_EN
    localparam int CRC_B = 1;
`else
    localparam int CRC_B = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, i_start, i_valid;
    logic [7:0] i_len, i_data;
    logic       o_ready, o_busy, o_done, o_err;
    logic [9:0] o_tx_out;

    int checks = 0;
    int failures = 0;
    int tx_log [0:NC];
    logic busy_log [0:NC];
    int busy_cyc, ready_cnt, first_ready, done_cnt, done_cyc, err_cnt, err_cyc;
    logic [7:0] exp_bytes [0:7];
    int first8 [0:7] = '{0, 0, 0, 0, 1023, 1023, 1023, 1023};

    vlc_tx_framer dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_len(i_len), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .o_tx_out(o_tx_out), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one frame request and log cycles 1..NC after the i_start edge.
    task automatic run(input logic [7:0] len, input logic [7:0] d0, input logic [7:0] d1,
                       input int drop_at, input int poke_at, input int rst_at);
        busy_cyc = 0; ready_cnt = 0; first_ready = -1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        i_len = len;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 1; cyc <= NC; cyc++) begin
            tx_log[cyc]   = int'(o_tx_out);
            busy_log[cyc] = o_busy;
            if (o_busy) busy_cyc++;
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_err) begin err_cnt++; err_cyc = cyc; end
            i_valid = 1'b0;
            if (o_ready) begin
                ready_cnt++;
                if (ready_cnt == 1) first_ready = cyc;
                i_valid = (ready_cnt != drop_at);
                i_data  = (ready_cnt == 1) ? d0 : d1;
            end
            i_start = (cyc == poke_at);
            reset   = (cyc != rst_at);
            @(negedge clk);
        end
        i_start = 1'b0;
        i_valid = 1'b0;
        reset   = 1'b1;
    endtask

    // Compare logged samples 1..upto against Manchester encoding of exp_bytes.
    task automatic compare(input string tag, input int upto);
        int mism;
        int idx;
        logic [7:0] b;
        logic bv, ch;
        mism = 0;
        for (int c = 1; c <= upto; c++) begin
            idx = c - 1;
            b   = exp_bytes[idx / 64];
            bv  = b[7 - (idx % 64) / 8];
            ch  = ((idx % 8) >= 4);
            if (tx_log[c] != ((bv ^ ch) ? 1023 : 0)) mism++;
        end
        check(tag, mism, 0);
    endtask

    function automatic int decode(input int k);
        int v;
        v = 0;
        for (int j = 0; j < 8; j++)
            v = (v << 1) | ((tx_log[1 + k * 64 + j * 8] == 1023) ? 1 : 0);
        return v;
    endfunction

    initial begin
        reset = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_len = 8'd0; i_data = 8'd0;
        exp_bytes = '{8'h55, 8'h55, 8'hA7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clk);
        @(negedge clk);
        check("rst_tx", int'(o_tx_out), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ready", int'(o_ready), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_err", int'(o_err), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte 0xA5 (CRC over 0x01,0xA5 is 0x67)
        exp_bytes[3] = 8'h01; exp_bytes[4] = 8'hA5; exp_bytes[5] = 8'h67;
        run(8'd1, 8'hA5, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) check("one_first8", tx_log[1 + i], first8[i]);
        compare("one_frame", (5 + CRC_B) * 64);
        check("one_busy_cycles", busy_cyc, (5 + CRC_B) * 64);
        check("one_ready_cnt", ready_cnt, 1);
        check("one_ready_cycle", first_ready, 256);
        check("one_done_cnt", done_cnt, 1);
        check("one_done_cycle", done_cyc, (5 + CRC_B) * 64 + 1);
        check("one_err_cnt", err_cnt, 0);
        check("one_done_tx", tx_log[(5 + CRC_B) * 64 + 1], 0);
        check("one_done_busy", int'(busy_log[(5 + CRC_B) * 64 + 1]), 0);
        check("one_idle_tx", tx_log[(5 + CRC_B) * 64 + 2], 0);
`ifdef TX_CRC8_EN
        check("one_crc_byte", decode(5), 8'h67);
`else
        check("one_last_byte", decode(4), 8'hA5);
`endif

        // Empty payload (CRC over 0x00 is 0x00)
        exp_bytes[3] = 8'h00; exp_bytes[4] = 8'h00;
        run(8'd0, 8'h00, 8'h00, 0, 0, 0);
        compare("empty_frame", (4 + CRC_B) * 64);
        check("empty_busy_cycles", busy_cyc, (4 + CRC_B) * 64);
        check("empty_ready_cnt", ready_cnt, 0);
        check("empty_done_cnt", done_cnt, 1);
        check("empty_done_cycle", done_cyc, (4 + CRC_B) * 64 + 1);

        // Underrun on the second payload byte
        exp_bytes[3] = 8'h02; exp_bytes[4] = 8'h3C;
        run(8'd2, 8'h3C, 8'hC3, 2, 0, 0);
        compare("underrun_frame", 320);
        check("underrun_ready_cnt", ready_cnt, 2);
        check("underrun_err_cnt", err_cnt, 1);
        check("underrun_err_cycle", err_cyc, 321);
        check("underrun_tx_after", tx_log[321], 0);
        check("underrun_busy_after", int'(busy_log[321]), 0);
        check("underrun_busy_cycles", busy_cyc, 320);
        check("underrun_done_cnt", done_cnt, 0);

        // i_start at cycle 50 ignored, reset at cycle 100
        exp_bytes[3] = 8'h01; exp_bytes[4] = 8'hA5; exp_bytes[5] = 8'h67;
        run(8'd1, 8'hA5, 8'h00, 0, 50, 100);
        compare("mid_frame_prefix", 100);
        check("mid_tx_after_rst", tx_log[101], 0);
        check("mid_busy_after_rst", int'(busy_log[101]), 0);
        check("mid_busy_cycles", busy_cyc, 100);
        check("mid_done_cnt", done_cnt, 0);
        check("mid_ready_cnt", ready_cnt, 0);

        // Fresh frame after the reset
        run(8'd1, 8'hA5, 8'h00, 0, 0, 0);
        compare("post_rst_frame", (5 + CRC_B) * 64);
        check("post_rst_done_cnt", done_cnt, 1);
        check("post_rst_done_cycle", done_cyc, (5 + CRC_B) * 64 + 1);
        check("post_rst_ready_cycle", first_ready, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vlc_tx_framer.md
VLC_TX_FRAMER -- requirements
Module: vlc_tx_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, DAC sample width.
REQ-002 SHALL have parameter SAMPLES_PER_CHIP, default 4, clocks each Manchester chip is held.
REQ-003 SHALL have parameter PREAMBLE_BYTES, default 2, count of 0x55 preamble bytes.
REQ-004 SHALL have parameter SFD, default 8'hA7, start-of-frame delimiter byte.
REQ-005 SHALL have parameters LEVEL_HI, default 1023, and LEVEL_LO, default 0, which are the DAC codes for light on and light off.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous, active-low reset.
REQ-008 SHALL have port i_start, input, 1 bit, frame request, sampled in IDLE only.
REQ-009 SHALL have port i_len, input, 8 bits, payload byte count (0..255), captured with i_start.
REQ-010 SHALL have port i_data, input, 8 bits, payload byte.
REQ-011 SHALL have port i_valid, input, 1 bit, i_data valid.
REQ-012 SHALL have port o_ready, output, 1 bit, payload byte request strobe.
REQ-013 SHALL have port o_tx_out, output, WIDTH bits, registered DAC sample stream.
REQ-014 SHALL have port o_busy, output, 1 bit, high from the first frame sample through the last.
REQ-015 SHALL have port o_done, output, 1 bit, 1-cycle pulse on frame completion.
REQ-016 SHALL have port o_err, output, 1 bit, 1-cycle pulse on payload underrun.

Function
REQ-017 SHALL implement states IDLE, PREAMBLE, SFD, LEN, PAYLOAD, CRC, DONE.
REQ-018 Frame order SHALL be PREAMBLE_BYTES x 0x55, then SFD, then i_len, then i_len payload bytes, then the optional CRC byte; every byte is sent MSB first.
REQ-019 Each bit SHALL be two chips: bit 1 gives LEVEL_HI then LEVEL_LO; bit 0 gives LEVEL_LO then LEVEL_HI; each chip lasts SAMPLES_PER_CHIP cycles.
REQ-020 When i_start=1 in IDLE, the first preamble sample SHALL appear on o_tx_out in the next cycle; the frame then occupies (PREAMBLE_BYTES+2+i_len[+1])*16*SAMPLES_PER_CHIP consecutive cycles with no gaps.
REQ-021 i_start SHALL be ignored while o_busy=1 and in DONE.
REQ-022 o_ready SHALL be high for exactly one cycle, namely the last cycle before each payload byte's first sample.
REQ-023 The byte SHALL be latched when i_valid=1 in that cycle.
REQ-024 If i_valid=0 in an o_ready cycle, the block SHALL pulse o_err and go to IDLE, with o_tx_out=LEVEL_LO and o_busy=0 from the next cycle; no o_done is produced.
REQ-025 If i_len=0, the block SHALL go from LEN to CRC or DONE and never assert o_ready.
REQ-026 After the last frame sample, DONE SHALL last one cycle with o_done=1, o_busy=0 and o_tx_out=LEVEL_LO; the block then returns to IDLE.
REQ-027 In IDLE, o_tx_out SHALL be LEVEL_LO.
REQ-028 Bit and sample counters SHALL wrap at the byte boundary without producing a glitch sample.

Reset
REQ-029 When reset=0 at a clock edge, the block SHALL enter IDLE at that edge, including in mid-frame.
REQ-030 The reset output values SHALL be o_tx_out=LEVEL_LO, o_busy=0, o_ready=0, o_done=0 and o_err=0.
REQ-031 Reset SHALL clear the CRC register, all counters and the latched length.

Configuration
REQ-032 With TX_CRC8_EN defined, the block SHALL append a CRC-8 byte after the payload: polynomial 0x07, initial value 0x00, no reflection, computed over the LEN byte and the payload bytes, using the CRC state.
REQ-033 Without TX_CRC8_EN, the CRC state and the CRC logic SHALL be absent; the frame ends after the last payload byte.

Verification
REQ-034 Reset test: hold reset=0 for 2 cycles -> o_tx_out=0, o_busy=0, o_ready=0, o_done=0, o_err=0.
REQ-035 Single-byte frame, CRC macro off: i_len=1, i_data=0xA5 -> first 8 samples are 0,0,0,0,1023,1023,1023,1023; the frame is 320 cycles; o_ready fires once; o_done pulses in cycle 321 after i_start.
REQ-036 Same stimulus with TX_CRC8_EN defined -> the frame is 384 cycles, and the final byte decodes as 0x67.
REQ-037 Empty payload: i_len=0 -> the frame is 256 cycles (macro off); o_ready is never asserted; o_done pulses once.
REQ-038 Underrun: i_len=2, i_valid=0 at the second o_ready -> o_err pulses; o_tx_out=0 and o_busy=0 from the next cycle; o_done is never asserted.
REQ-039 Mid-frame events: i_start pulsed at cycle 50 of a frame -> ignored; reset=0 at cycle 100 -> o_tx_out=0 and IDLE after that edge; a new i_start after reset=1 -> a complete frame is sent.
